// File: rtl/vregfile_if.sv
// Bundle of the vregfile write, read and serial-load signals.
// The master side drives addresses/data/controls; the slave (the register file) returns read data and loader status.
interface vregfile_if #(
   parameter int WIDTH        = 24,
   parameter int ADDRESSWIDTH = 4,
   parameter int LANES        = 4,
   parameter int VADDRWIDTH   = 3
);
   localparam int LENW = $clog2(LANES) + 1;

   logic                    we3;
   logic                    isvector;
   logic                    vect_esc;
   logic [ADDRESSWIDTH-1:0] ra1;
   logic [ADDRESSWIDTH-1:0] ra2;
   logic [ADDRESSWIDTH-1:0] wa3;
   logic [WIDTH-1:0]        wd3;
   logic [WIDTH-1:0]        PC;
   logic [WIDTH-1:0]        rd1;
   logic [WIDTH-1:0]        rd2;
   logic [VADDRWIDTH-1:0]   vra1;
   logic [VADDRWIDTH-1:0]   vra2;
   logic [LANES*WIDTH-1:0]  vwd3;
   logic [LANES-1:0]        vmask;
   logic [LANES*WIDTH-1:0]  vrd1;
   logic [LANES*WIDTH-1:0]  vrd2;
   logic                    ld_start;
   logic [VADDRWIDTH-1:0]   ld_addr;
   logic [LENW-1:0]         ld_len;
   logic                    ld_valid;
   logic [WIDTH-1:0]        ld_data;
   logic                    ld_ready;
   logic                    ld_busy;
   logic                    ld_done;
   logic                    wr_conflict;

   modport master (
      output we3, isvector, vect_esc, ra1, ra2, wa3, wd3, PC,
      output vra1, vra2, vwd3, vmask,
      output ld_start, ld_addr, ld_len, ld_valid, ld_data,
      input  rd1, rd2, vrd1, vrd2, ld_ready, ld_busy, ld_done, wr_conflict
   );

   modport slave (
      input  we3, isvector, vect_esc, ra1, ra2, wa3, wd3, PC,
      input  vra1, vra2, vwd3, vmask,
      input  ld_start, ld_addr, ld_len, ld_valid, ld_data,
      output rd1, rd2, vrd1, vrd2, ld_ready, ld_busy, ld_done, wr_conflict
   );
endinterface

// File: rtl/vregfile.sv
// Scalar + vector register file (top scalar index aliases PC); combinational reads, writes on the clock edge.
// Serial loader streams elements into one vector register under ld_valid/ld_ready; ld_valid=0 simply stalls it.
module vregfile #(
   parameter int WIDTH        = 24,
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4,
   parameter int LANES        = 4,
   parameter int VREGNUM      = 8,
   parameter int VADDRWIDTH   = 3
) (
   input  logic      clk,
   input  logic      reset,
   vregfile_if.slave bus
);
   localparam int LENW = $clog2(LANES) + 1;
   localparam int VW   = LANES * WIDTH;
   localparam logic [ADDRESSWIDTH-1:0] PC_IDX = ADDRESSWIDTH'(REGNUM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ld_state_t;

   logic [WIDTH-1:0]      r_sreg [REGNUM];
   logic [VW-1:0]         r_vreg [VREGNUM];

   ld_state_t             r_state;
   logic [VADDRWIDTH-1:0] r_ld_addr;
   logic [LENW-1:0]       r_len;
   logic [LENW-1:0]       r_idx;
   logic                  r_ld_ready;
   logic                  r_ld_busy;
   logic                  r_ld_done;

   logic [VADDRWIDTH-1:0] w_vwa;
   logic [LENW-1:0]       w_ld_len;
   logic                  w_swe;
   logic                  w_vreq;
   logic                  w_conflict;
   logic                  w_vwe;
   logic                  w_ld_we;
   logic [VW-1:0]         w_vnew;

   // Read ports: no bypass, so a same-cycle write is only visible after the edge.
   assign bus.rd1  = (bus.ra1 == PC_IDX) ? bus.PC : r_sreg[bus.ra1];
   assign bus.rd2  = (bus.ra2 == PC_IDX) ? bus.PC : r_sreg[bus.ra2];
   assign bus.vrd1 = r_vreg[bus.vra1];
   assign bus.vrd2 = r_vreg[bus.vra2];

   assign w_vwa      = bus.wa3[VADDRWIDTH-1:0];
   assign w_ld_len   = (bus.ld_len > LENW'(LANES)) ? LENW'(LANES) : bus.ld_len;
   assign w_swe      = bus.we3 && !bus.isvector && (bus.wa3 != PC_IDX);
   assign w_vreq     = bus.we3 && bus.isvector;
   // The loader owns its target register until it returns to IDLE.
   assign w_conflict = w_vreq && r_ld_busy && (w_vwa == r_ld_addr) && !reset;
   assign w_vwe      = w_vreq && !w_conflict;
   assign w_ld_we    = (r_state == LOAD) && bus.ld_valid;

   assign bus.ld_ready    = r_ld_ready;
   assign bus.ld_busy     = r_ld_busy;
   assign bus.ld_done     = r_ld_done;
   assign bus.wr_conflict = w_conflict;

   always_comb begin
      w_vnew = r_vreg[w_vwa];
      for (int i = 0; i < LANES; i++) begin
         if (bus.vmask[i]) begin
            w_vnew[i*WIDTH +: WIDTH] = bus.vect_esc ? bus.wd3 : bus.vwd3[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REGNUM; i++) r_sreg[i] <= '0;
         for (int i = 0; i < VREGNUM; i++) r_vreg[i] <= '0;
      end else begin
         if (w_swe) r_sreg[bus.wa3] <= bus.wd3;
         if (w_vwe) r_vreg[w_vwa] <= w_vnew;
         if (w_ld_we) r_vreg[r_ld_addr][int'(r_idx)*WIDTH +: WIDTH] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_ld_addr  <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_ld_ready <= 1'b0;
         r_ld_busy  <= 1'b0;
         r_ld_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ld_done <= 1'b0;
               if (bus.ld_start) begin
                  r_ld_addr <= bus.ld_addr;
                  r_len     <= w_ld_len;
                  r_idx     <= '0;
                  r_ld_busy <= 1'b1;
                  if (w_ld_len == '0) begin
                     r_state   <= DONE;
                     r_ld_done <= 1'b1;
                  end else begin
                     r_state    <= LOAD;
                     r_ld_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (bus.ld_valid) begin
                  r_idx <= r_idx + LENW'(1);
                  if (r_idx == r_len - LENW'(1)) begin
                     r_state    <= DONE;
                     r_ld_ready <= 1'b0;
                     r_ld_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state   <= IDLE;
               r_ld_done <= 1'b0;
               r_ld_busy <= 1'b0;
            end
            default: begin
               r_state    <= IDLE;
               r_ld_ready <= 1'b0;
               r_ld_busy  <= 1'b0;
               r_ld_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vregfile.sv
// Bench for vregfile: directed scenarios then random traffic, all checked against an array-based reference model.
module tb_vregfile;
   localparam int W = 24;
   localparam int L = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   vregfile_if bus ();

   vregfile dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays per register/lane plus a description of the pending load.
   logic [W-1:0] sm [16];
   logic [W-1:0] vm [8][L];
   bit           m_act;
   bit           m_done;
   int           m_tgt;
   int           m_lane;
   int           m_left;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] vpack(input int r);
      logic [95:0] v;
      v = '0;
      for (int i = 0; i < L; i++) v[i*W +: W] = vm[r][i];
      return v;
   endfunction

   function automatic logic [W-1:0] exp_rd(input int a);
      return (a == 15) ? bus.PC : sm[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) sm[i] = '0;
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < L; i++) vm[r][i] = '0;
      m_act = 0; m_done = 0; m_lane = 0; m_left = 0; m_tgt = 0;
   endtask

   function automatic bit exp_conflict();
      return !reset && bus.we3 && bus.isvector && (m_act || m_done) &&
             (int'(bus.wa3[2:0]) == m_tgt);
   endfunction

   task automatic model_step();
      int len;
      if (reset) begin
         model_clear();
         return;
      end
      if (bus.we3 && !bus.isvector && bus.wa3 != 4'd15) sm[bus.wa3] = bus.wd3;
      if (bus.we3 && bus.isvector && !exp_conflict()) begin
         for (int i = 0; i < L; i++)
            if (bus.vmask[i]) vm[bus.wa3[2:0]][i] = bus.vect_esc ? bus.wd3 : bus.vwd3[i*W +: W];
      end
      if (m_done) begin
         m_done = 0;
      end else if (m_act) begin
         if (bus.ld_valid) begin
            vm[m_tgt][m_lane] = bus.ld_data;
            m_lane++;
            m_left--;
            if (m_left == 0) begin m_act = 0; m_done = 1; end
         end
      end else if (bus.ld_start) begin
         len    = (int'(bus.ld_len) > L) ? L : int'(bus.ld_len);
         m_tgt  = int'(bus.ld_addr);
         m_lane = 0;
         m_left = len;
         if (len == 0) m_done = 1;
         else m_act = 1;
      end
   endtask

   task automatic check_all();
      chk("rd1", 96'(bus.rd1), 96'(exp_rd(int'(bus.ra1))));
      chk("rd2", 96'(bus.rd2), 96'(exp_rd(int'(bus.ra2))));
      chk("vrd1", bus.vrd1, vpack(int'(bus.vra1)));
      chk("vrd2", bus.vrd2, vpack(int'(bus.vra2)));
      chk("ld_ready", 96'(bus.ld_ready), 96'(m_act));
      chk("ld_busy", 96'(bus.ld_busy), 96'(m_act || m_done));
      chk("ld_done", 96'(bus.ld_done), 96'(m_done));
   endtask

   // Check current outputs against the model, then advance both by one clock.
   task automatic cyc();
      #1;
      check_all();
      chk("wr_conflict", 96'(bus.wr_conflict), 96'(exp_conflict()));
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.we3 = 0; bus.isvector = 0; bus.vect_esc = 0;
      bus.ld_start = 0; bus.ld_valid = 0;
   endtask

   initial begin
      int acc;
      logic [95:0] v;
      reset = 1;
      bus.ra1 = 0; bus.ra2 = 0; bus.wa3 = 0; bus.wd3 = 0; bus.PC = 0;
      bus.vra1 = 0; bus.vra2 = 0; bus.vwd3 = '0; bus.vmask = 0;
      bus.ld_addr = 0; bus.ld_len = 0; bus.ld_data = 0;
      idle_inputs();
      @(posedge clk);
      #1;
      model_clear();

      // Reset wins over a concurrent scalar write and a load start.
      bus.we3 = 1; bus.wa3 = 4'd3; bus.wd3 = 24'h123456;
      bus.ld_start = 1; bus.ld_len = 3'd2;
      cyc();
      idle_inputs();
      bus.ra1 = 4'd3;
      cyc();
      chk("reset_rd1", 96'(bus.rd1), 96'(0));
      chk("reset_busy", 96'(bus.ld_busy), 96'(0));
      reset = 0;

      // Scalar write, PC alias and discarded PC write.
      bus.we3 = 1; bus.wa3 = 4'd3; bus.wd3 = 24'h00ABCD; bus.ra1 = 4'd3;
      #1;
      chk("no_bypass", 96'(bus.rd1), 96'(0));
      cyc();
      bus.we3 = 0; bus.ra2 = 4'd15; bus.PC = 24'h000100;
      #1;
      chk("scalar_rd1", 96'(bus.rd1), 96'(24'h00ABCD));
      chk("pc_rd2", 96'(bus.rd2), 96'(24'h000100));
      bus.we3 = 1; bus.wa3 = 4'd15; bus.wd3 = 24'h555555;
      cyc();
      bus.we3 = 0;
      cyc();
      chk("pc_after_wr", 96'(bus.rd2), 96'(24'h000100));

      // Masked vector write then broadcast.
      bus.we3 = 1; bus.isvector = 1; bus.wa3 = 4'd2; bus.vmask = 4'b0101;
      bus.vwd3 = {24'd4, 24'd3, 24'd2, 24'd1}; bus.vra1 = 3'd2;
      cyc();
      bus.we3 = 0;
      #1;
      chk("vmask_wr", bus.vrd1, {24'd0, 24'd3, 24'd0, 24'd1});
      bus.we3 = 1; bus.vect_esc = 1; bus.wd3 = 24'd7; bus.vmask = 4'b1111;
      cyc();
      idle_inputs();
      #1;
      chk("vbcast", bus.vrd1, {24'd7, 24'd7, 24'd7, 24'd7});

      // Serial load into v5 with a stall and a conflicting write.
      bus.ld_start = 1; bus.ld_addr = 3'd5; bus.ld_len = 3'd3; bus.vra1 = 3'd5; bus.vra2 = 3'd1;
      cyc();
      bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 24'd10;
      cyc();
      bus.ld_valid = 0;
      bus.we3 = 1; bus.isvector = 1; bus.wa3 = 4'd5; bus.vmask = 4'b1111;
      bus.vwd3 = {24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB};
      #1;
      chk("conflict_v5", 96'(bus.wr_conflict), 96'(1));
      cyc();
      bus.wa3 = 4'd1; bus.ld_valid = 1; bus.ld_data = 24'd11;
      #1;
      chk("noconflict_v1", 96'(bus.wr_conflict), 96'(0));
      cyc();
      idle_inputs();
      #1;
      chk("v1_written", bus.vrd2, {24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB});
      bus.ld_valid = 1; bus.ld_data = 24'd12;
      cyc();
      bus.ld_valid = 0;
      #1;
      chk("ld_done_pulse", 96'(bus.ld_done), 96'(1));
      cyc();
      chk("ld_done_clear", 96'(bus.ld_done), 96'(0));
      chk("v5_loaded", bus.vrd1, {24'd0, 24'd12, 24'd11, 24'd10});

      // Zero-length load and over-length load.
      bus.ld_start = 1; bus.ld_addr = 3'd6; bus.ld_len = 3'd0; bus.vra1 = 3'd6;
      cyc();
      bus.ld_start = 0;
      #1;
      chk("len0_done", 96'(bus.ld_done), 96'(1));
      cyc();
      chk("len0_v6", bus.vrd1, 96'(0));
      bus.ld_start = 1; bus.ld_addr = 3'd4; bus.ld_len = 3'd7; bus.vra1 = 3'd4;
      cyc();
      bus.ld_start = 0; bus.ld_valid = 1;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         bus.ld_data = 24'(100 + k);
         #1;
         if (bus.ld_ready) acc++;
         cyc();
      end
      bus.ld_valid = 0;
      chk("len7_xfers", 96'(acc), 96'(4));
      chk("len7_v4", bus.vrd1, {24'd103, 24'd102, 24'd101, 24'd100});

      // Reset in the middle of a load.
      bus.ld_start = 1; bus.ld_addr = 3'd3; bus.ld_len = 3'd4; bus.vra1 = 3'd3;
      cyc();
      bus.ld_start = 0; bus.ld_valid = 1;
      bus.ld_data = 24'hAAAAAA; cyc();
      bus.ld_data = 24'hBBBBBB; cyc();
      reset = 1;
      cyc();
      reset = 0; bus.ld_valid = 0; bus.vra1 = 3'd5;
      #1;
      chk("rst_busy", 96'(bus.ld_busy), 96'(0));
      chk("rst_v5", bus.vrd1, 96'(0));
      cyc();
      chk("rst_nodone", 96'(bus.ld_done), 96'(0));
      bus.ld_start = 1; bus.ld_addr = 3'd3; bus.ld_len = 3'd2; bus.vra1 = 3'd3;
      cyc();
      bus.ld_start = 0; bus.ld_valid = 1;
      bus.ld_data = 24'd21; cyc();
      bus.ld_data = 24'd22; cyc();
      bus.ld_valid = 0;
      cyc();
      chk("reload_v3", bus.vrd1, {24'd0, 24'd0, 24'd22, 24'd21});

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         reset         = ($urandom_range(0, 99) == 0);
         bus.we3       = $urandom_range(0, 1);
         bus.isvector  = $urandom_range(0, 1);
         bus.vect_esc  = $urandom_range(0, 1);
         bus.wa3       = 4'($urandom_range(0, 15));
         bus.wd3       = 24'($urandom);
         bus.ra1       = 4'($urandom_range(0, 15));
         bus.ra2       = 4'($urandom_range(0, 15));
         bus.PC        = 24'($urandom);
         bus.vra1      = 3'($urandom_range(0, 7));
         bus.vra2      = 3'($urandom_range(0, 7));
         bus.vmask     = 4'($urandom_range(0, 15));
         for (int i = 0; i < L; i++) v[i*W +: W] = 24'($urandom);
         bus.vwd3      = v;
         bus.ld_start  = ($urandom_range(0, 7) == 0);
         bus.ld_addr   = 3'($urandom_range(0, 7));
         bus.ld_len    = 3'($urandom_range(0, 7));
         bus.ld_valid  = $urandom_range(0, 1);
         bus.ld_data   = 24'($urandom);
         cyc();
      end
      reset = 0;
      idle_inputs();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vregfile.md
VREGFILE -- requirements
Module: vregfile

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 24, bit width of one scalar register and one vector element.
REQ-002 The module SHALL expose parameter REGNUM, default 16, scalar register count; the top index REGNUM-1 is the PC alias.
REQ-003 The module SHALL expose parameter ADDRESSWIDTH, default 4, width of the scalar address ports.
REQ-004 The module SHALL expose parameter LANES, default 4, element count per vector register.
REQ-005 The module SHALL expose parameter VREGNUM, default 8, vector register count.
REQ-006 The module SHALL expose parameter VADDRWIDTH, default 3, width of the vector address ports.
REQ-007 The module SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-008 Write controls SHALL be: we3  in  1  write enable; isvector  in  1  vector target; vect_esc  in  1  scalar-broadcast mode.
REQ-009 Scalar ports SHALL be: ra1, ra2, wa3  in  ADDRESSWIDTH  addresses; wd3, PC  in  WIDTH; rd1, rd2  out  WIDTH.
REQ-010 Vector ports SHALL be: vra1, vra2  in  VADDRWIDTH; vwd3  in  LANES*WIDTH; vmask  in  LANES  lane write mask; vrd1, vrd2  out  LANES*WIDTH.
REQ-011 Serial-load ports SHALL be: ld_start  in  1; ld_addr  in  VADDRWIDTH; ld_len  in  $clog2(LANES)+1; ld_valid  in  1; ld_data  in  WIDTH; ld_ready  out  1; ld_busy  out  1; ld_done  out  1; wr_conflict  out  1.

Function
REQ-012 rd1/rd2 SHALL be combinational: PC when the address equals REGNUM-1, otherwise the addressed scalar register.
REQ-013 vrd1/vrd2 SHALL be combinational reads of the addressed vector register; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-014 we3=1, isvector=0 SHALL write wd3 to scalar wa3 on the clock edge; writes to wa3=REGNUM-1 are discarded.
REQ-015 we3=1, isvector=1, vect_esc=0 SHALL write each lane i of vwd3 into vector register wa3[VADDRWIDTH-1:0] where vmask[i]=1; unmasked lanes hold.
REQ-016 we3=1, isvector=1, vect_esc=1 SHALL write wd3 into every lane with vmask[i]=1 of vector register wa3[VADDRWIDTH-1:0].
REQ-017 Reads SHALL return pre-write contents in the write cycle (no write-through bypass).
REQ-018 The serial loader SHALL be an FSM with states IDLE, LOAD, DONE.
REQ-019 IDLE: ld_start=1 latches ld_addr and len=min(ld_len,LANES), clears element index to 0, goes to LOAD; if len=0, goes straight to DONE.
REQ-020 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data into lane index of the target register and increments index; the transfer with index=len-1 moves to DONE.
REQ-021 LOAD: cycles with ld_valid=0 SHALL hold state and index without writing.
REQ-022 DONE: ld_done SHALL pulse for exactly one cycle, then the FSM returns to IDLE.
REQ-023 ld_busy SHALL be 1 in LOAD and DONE; ld_start in those states SHALL be ignored.
REQ-024 During LOAD/DONE, a REQ-015/016 vector write to the load target register SHALL be dropped and wr_conflict pulsed for that cycle; writes to other vector registers and all scalar writes proceed.
REQ-025 ld_ready and ld_done SHALL be 0 outside LOAD and DONE respectively; wr_conflict 0 when no conflict.

Reset
REQ-026 reset=1 at a clock edge SHALL clear all scalar and vector registers to 0 and force IDLE, index 0, ld_ready=ld_busy=ld_done=wr_conflict=0.
REQ-027 reset SHALL take priority over every write and load in the same cycle, including mid-LOAD; the aborted load produces no ld_done.

Verification
REQ-028 Scalar: write wd3=24'h00ABCD to wa3=3, then ra1=3, ra2=15 with PC=24'h000100 -> rd1=24'h00ABCD, rd2=24'h000100; write to wa3=15 leaves the PC read unchanged.
REQ-029 Masked vector write: vmask=4'b0101, vwd3={4,3,2,1} to v2 -> vrd1 lanes {0,3,0,1}; broadcast wd3=7, vmask=4'b1111 to v2 -> all lanes 7.
REQ-030 Serial load: ld_start, ld_addr=5, ld_len=3, data 10,11,12 with one ld_valid=0 gap -> v5 lanes {0,12,11,10}, ld_done one cycle after the third transfer.
REQ-031 Boundaries: ld_len=0 -> DONE next cycle, v unchanged; ld_len=7 with LANES=4 -> exactly 4 transfers accepted.
REQ-032 Conflict: during LOAD to v5, vector write to v5 -> dropped, wr_conflict=1; same-cycle write to v1 -> succeeds, no conflict.
REQ-033 Reset mid-LOAD after 2 transfers -> all registers 0, ld_busy=0, no ld_done; a new load then completes normally.
